spad_fill_ctrl: RTL and testbench

- Drain controller that sits directly downstream of the PE input sync FIFO wrapper and consumes its narrow read side.
- Pops a programmed number of words from the FIFO and writes them into a PE scratchpad (ifmap or filter spad) at consecutive addresses.
- Addresses start at a programmable base and wrap at SPAD_DEPTH.
- Signals busy while filling and emits a one-cycle done pulse when the last word is written, so PE control can start MAC processing.

---
 rtl/spad_fill_ctrl.sv | 122 ++++++++++++
 tb/tb_spad_fill_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spad_fill_ctrl.sv
// spad_fill_ctrl: drains a programmed number of words from the PE input sync
// FIFO into a PE scratchpad at consecutive, wrapping addresses, then pulses
// done so PE control can start MAC processing.
// Optional feature macro: SPAD_FILL_STALL_CNT_EN adds a saturating count of
// cycles spent waiting on an empty FIFO while words are still owed.
module spad_fill_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int SPAD_DEPTH = 224,
  parameter int ADDR_WIDTH = $clog2(SPAD_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH:0]   fill_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_read_request,
  output logic                  spad_we,
  output logic [ADDR_WIDTH-1:0] spad_waddr,
  output logic [DATA_WIDTH-1:0] spad_wdata,
  output logic                  busy,
`ifdef SPAD_FILL_STALL_CNT_EN
  output logic                  done,
  output logic [15:0]           stall_cycles
`else
  output logic                  done
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic [ADDR_WIDTH:0]   written_q;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] waddr_p1;
  logic                  accept;

  // Next write address; the last entry folds back to zero.
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(SPAD_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Increment that sticks at all-ones instead of rolling over.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept = (state_q == IDLE) && start;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (fill_len != '0) ? FILL : DONE;
      FILL: if (fifo_read_request && (issued_q + 1'b1 == len_q)) state_d = WAIT;
      WAIT: if (vld_p1 && (written_q + 1'b1 == len_q)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; the pop request also watches fifo_empty.
  always_comb begin
    fifo_read_request = (state_q == FILL) && !fifo_empty && (issued_q != len_q);
    busy              = (state_q != IDLE) && (state_q != DONE);
    done              = (state_q == DONE);
  end

  // Transfer bookkeeping: captured length plus issued/written word counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      issued_q  <= '0;
      written_q <= '0;
    end else if (accept) begin
      len_q     <= fill_len;
      issued_q  <= '0;
      written_q <= '0;
    end else begin
      if (fifo_read_request) issued_q  <= issued_q + 1'b1;
      if (vld_p1)            written_q <= written_q + 1'b1;
    end
  end

  // ---- stage p1: FIFO data returns one cycle after the pop and is written straight through
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
    end else begin
      vld_p1 <= fifo_read_request;
      if (accept)      waddr_p1 <= fill_base;
      else if (vld_p1) waddr_p1 <= wrap_inc(waddr_p1);
    end
  end

  assign spad_we    = vld_p1;
  assign spad_waddr = waddr_p1;
  assign spad_wdata = fifo_rd_data;

`ifdef SPAD_FILL_STALL_CNT_EN
  // Cycles lost to an empty FIFO while words are still owed; held after done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (accept)
      stall_cycles <= '0;
    else if ((state_q == FILL) && fifo_empty && (issued_q != len_q))
      stall_cycles <= sat_inc16(stall_cycles);
  end
`endif

endmodule

// File: tb/tb_spad_fill_ctrl.sv
// tb_spad_fill_ctrl: randomized and directed fills against a queue-based FIFO
// and a scoreboard of expected (address, data) writes derived from the
// transfer description (base, length, pushed words).
module tb_spad_fill_ctrl;
  localparam int DW    = 16;
  localparam int DEPTH = 224;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_len;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_read_request, spad_we, busy, done;
  logic [AW-1:0] spad_waddr;
  logic [DW-1:0] spad_wdata;
`ifdef SPAD_FILL_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  spad_fill_ctrl #(.DATA_WIDTH(DW), .SPAD_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .fill_base(fill_base), .fill_len(fill_len),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_read_request(fifo_read_request), .spad_we(spad_we), .spad_waddr(spad_waddr),
    .spad_wdata(spad_wdata), .busy(busy),
`ifdef SPAD_FILL_STALL_CNT_EN
    .done(done), .stall_cycles(stall_cycles)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Upstream FIFO model: popped word appears the cycle after the request.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] feed_q[$];
  logic [DW-1:0] exp_q[$];
  int  hold = 0;
  bit  rand_feed = 0;
  bit  req_s = 0;
  int  cyc = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (reset) begin
      fifo_q.delete();
      feed_q.delete();
      fifo_rd_data = '0;
    end else begin
      if (req_s && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      if (hold > 0) hold--;
      else if (feed_q.size() > 0 && (!rand_feed || $urandom_range(1) == 1))
        fifo_q.push_back(feed_q.pop_front());
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor: logs writes/done/busy relative to the start cycle and tracks stalls.
  int  cyc0 = 0;
  bit  armed = 0;
  int  pops_m, stall_m, len_m;
  int  wr_addr[$], wr_data[$], wr_cyc[$], done_cyc[$];
  int  busy_n, busy_first, req_n;

  always @(negedge clk) begin
    req_s = reset ? 1'b0 : fifo_read_request;
    if (!reset) begin
      if (armed) chk("req_while_empty", 32'(fifo_read_request & fifo_empty), 0);
      if (spad_we) begin
        wr_addr.push_back(int'(spad_waddr));
        wr_data.push_back(int'(spad_wdata));
        wr_cyc.push_back(cyc - cyc0);
      end
      if (done) done_cyc.push_back(cyc - cyc0);
      if (busy) begin
        if (busy_n == 0) busy_first = cyc - cyc0;
        busy_n++;
      end
      if (fifo_read_request) req_n++;
      if (armed && (cyc - cyc0) >= 1 && pops_m < len_m) begin
        if (fifo_empty) stall_m++;
        if (fifo_read_request) pops_m++;
      end
    end
  end

  task automatic preload(input logic [DW-1:0] w);
    exp_q.push_back(w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] w);
    exp_q.push_back(w);
    feed_q.push_back(w);
  endtask

  task automatic do_start(input int base, input int len);
    @(negedge clk);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
    busy_n = 0; req_n = 0; pops_m = 0; stall_m = 0; len_m = len;
    fill_base = AW'(base);
    fill_len  = (AW+1)'(len);
    start = 1'b1;
    cyc0  = cyc;
    armed = 1'b1;
  endtask

  task automatic run_fill(input int base, input int len, input bit never_empty, input int restart_at);
    int budget;
    int n;
    budget = len * 30 + 100;
    do_start(base, len);
    for (int k = 0; k < budget && done_cyc.size() == 0; k++) begin
      @(negedge clk);
      start = ((cyc - cyc0) == restart_at);
      if (start) begin
        fill_base = AW'($urandom_range(DEPTH - 1));
        fill_len  = (AW+1)'(5);
      end
    end
    start = 1'b0;
    chk("timeout", 32'(done_cyc.size() > 0), 1);
    repeat (4) @(negedge clk);
    chk("done_count", done_cyc.size(), 1);
    chk("write_count", wr_addr.size(), len);
    chk("pop_count", req_n, len);
    n = (wr_addr.size() < len) ? wr_addr.size() : len;
    for (int i = 0; i < n; i++) begin
      chk("waddr", wr_addr[i], (base + i) % DEPTH);
      chk("wdata", wr_data[i], int'(exp_q[i]));
    end
    if (never_empty && done_cyc.size() > 0) begin
      chk("done_cycle", done_cyc[0], (len == 0) ? 1 : len + 2);
      chk("busy_cycles", busy_n, (len == 0) ? 0 : len + 1);
      if (len > 0) begin
        chk("busy_first", busy_first, 1);
        if (wr_cyc.size() > 0) begin
          chk("first_write_cycle", wr_cyc[0], 2);
          chk("last_write_cycle", wr_cyc[wr_cyc.size() - 1], len + 1);
        end
      end
    end
`ifdef SPAD_FILL_STALL_CNT_EN
    chk("stall_cycles", int'(stall_cycles), stall_m);
`endif
    armed = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int len, base, pre;
    reset = 1'b1; start = 1'b0; fill_base = '0; fill_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(fifo_read_request), 0);
    chk("rst_we", 32'(spad_we), 0);
    chk("rst_waddr", 32'(spad_waddr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic fill of words 1..8 at base 10.
    for (int i = 1; i <= 8; i++) preload(DW'(i));
    run_fill(10, 8, 1, -1);

    // Address wrap at the top of the scratchpad.
    for (int i = 0; i < 4; i++) preload(DW'($urandom));
    run_fill(222, 4, 1, -1);

    // Underflow: 2 words now, 3 more after a delay.
    rand_feed = 0;
    for (int i = 0; i < 2; i++) preload(DW'($urandom));
    for (int i = 0; i < 3; i++) feed(DW'($urandom));
    hold = 5;
    run_fill(40, 5, 0, -1);

    // Zero length.
    run_fill(50, 0, 1, -1);

    // Second start during an active fill is ignored.
    for (int i = 0; i < 8; i++) preload(DW'($urandom));
    run_fill(5, 8, 1, 3);

    // Reset in the middle of a 16-word fill.
    for (int i = 0; i < 16; i++) preload(DW'($urandom));
    do_start(30, 16);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_req", 32'(fifo_read_request), 0);
    chk("midrst_we", 32'(spad_we), 0);
    chk("midrst_waddr", 32'(spad_waddr), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    armed = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) preload(DW'($urandom));
    run_fill(100, 6, 1, -1);

    // Randomized fills with a bursty upstream.
    for (int it = 0; it < 6; it++) begin
      len  = $urandom_range(1, 40);
      base = $urandom_range(0, DEPTH - 1);
      pre  = $urandom_range(0, len);
      rand_feed = 1;
      hold = $urandom_range(0, 3);
      for (int i = 0; i < pre; i++) preload(DW'($urandom));
      for (int i = pre; i < len; i++) feed(DW'($urandom));
      run_fill(base, len, (pre == len), -1);
    end

    // Full-depth fill.
    rand_feed = 0;
    for (int i = 0; i < DEPTH; i++) preload(DW'($urandom));
    run_fill(7, DEPTH, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
